// File: rtl/fetch_pair_queue_if.sv
// Handshake bundle between fetch, the pair queue and dual decode.
// The master side is fetch/decode. The slave side is the queue.
interface fetch_pair_queue_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              flush;
  logic [1:0]        in_count;
  logic [ADDR_W-1:0] in_pc0;
  logic [DATA_W-1:0] in_instr0;
  logic [ADDR_W-1:0] in_pc1;
  logic [DATA_W-1:0] in_instr1;
  logic              in_ready;
  logic [1:0]        deq_count;
  logic              out_valid0;
  logic [ADDR_W-1:0] out_pc0;
  logic [DATA_W-1:0] out_instr0;
  logic              out_valid1;
  logic [ADDR_W-1:0] out_pc1;
  logic [DATA_W-1:0] out_instr1;
  logic [CntW-1:0]   count;

  modport master (
    output flush, in_count, in_pc0, in_instr0, in_pc1, in_instr1, deq_count,
    input  in_ready, out_valid0, out_pc0, out_instr0, out_valid1, out_pc1, out_instr1, count
  );

  modport slave (
    input  flush, in_count, in_pc0, in_instr0, in_pc1, in_instr1, deq_count,
    output in_ready, out_valid0, out_pc0, out_instr0, out_valid1, out_pc1, out_instr1, count
  );
endinterface

// File: rtl/fetch_pair_queue.sv
// Dual-issue in-order instruction queue. Up to two {pc, instr} pushes and pops per cycle.
// Reads are show-ahead. Pushes are accepted only in pairs of free space.
module fetch_pair_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input logic               clock,
  input logic               reset,
  fetch_pair_queue_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [DATA_W-1:0] instr_mem_d [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            ready;
  logic [1:0]      enq;
  logic [1:0]      deq_req;
  logic [1:0]      deq;
  logic [PtrW-1:0] rd_ptr_p1;
  logic [PtrW-1:0] wr_ptr_p1;

  assign rd_ptr_p1 = rd_ptr_q + 1'b1;
  assign wr_ptr_p1 = wr_ptr_q + 1'b1;

  // Acceptance uses registered occupancy only, so a same-cycle pop never frees space.
  assign ready = (cnt_q <= CntW'(DEPTH - 2));

  always_comb begin
    enq     = 2'd0;
    deq_req = bus.deq_count;
    deq     = 2'd0;
    if (ready && (bus.in_count != 2'd3)) begin
      enq = bus.in_count;
    end
    if (bus.deq_count == 2'd3) begin
      deq_req = 2'd2;
    end
    if ({{(CntW-2){1'b0}}, deq_req} > cnt_q) begin
      deq = cnt_q[1:0];
    end else begin
      deq = deq_req;
    end
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq != 2'd0) begin
        pc_mem_d[wr_ptr_q]    = bus.in_pc0;
        instr_mem_d[wr_ptr_q] = bus.in_instr0;
      end
      if (enq == 2'd2) begin
        pc_mem_d[wr_ptr_p1]    = bus.in_pc1;
        instr_mem_d[wr_ptr_p1] = bus.in_instr1;
      end
      wr_ptr_d = wr_ptr_q + PtrW'(enq);
      rd_ptr_d = rd_ptr_q + PtrW'(deq);
      cnt_d    = cnt_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clock) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  always_comb begin
    bus.out_valid0 = (cnt_q != '0);
    bus.out_valid1 = (cnt_q >= CntW'(2));
    bus.out_pc0    = '0;
    bus.out_instr0 = '0;
    bus.out_pc1    = '0;
    bus.out_instr1 = '0;
    if (bus.out_valid0) begin
      bus.out_pc0    = pc_mem_q[rd_ptr_q];
      bus.out_instr0 = instr_mem_q[rd_ptr_q];
    end
    if (bus.out_valid1) begin
      bus.out_pc1    = pc_mem_q[rd_ptr_p1];
      bus.out_instr1 = instr_mem_q[rd_ptr_p1];
    end
  end

  assign bus.in_ready = ready;
  assign bus.count    = cnt_q;
endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue with a queue scoreboard of the expected contents.
module tb_fetch_pair_queue;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } ent_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  ent_t sb[$];

  fetch_pair_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_pair_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_instr(input logic [ADDR_W-1:0] pc);
    return {8'h28, 12'h5A3, pc} ^ 32'h0040_0000;
  endfunction

  // Compare every output against the scoreboard's view of the queue.
  task automatic check_outputs();
    int n;
    logic [ADDR_W-1:0] p0, p1;
    logic [DATA_W-1:0] i0, i1;
    n  = sb.size();
    p0 = '0;
    p1 = '0;
    i0 = '0;
    i1 = '0;
    if (n >= 1) begin
      p0 = sb[0].pc;
      i0 = sb[0].instr;
    end
    if (n >= 2) begin
      p1 = sb[1].pc;
      i1 = sb[1].instr;
    end
    check("count", 64'(bus.count), 64'(n));
    check("in_ready", 64'(bus.in_ready), 64'((DEPTH - n) >= 2));
    check("out_valid0", 64'(bus.out_valid0), 64'(n >= 1));
    check("out_valid1", 64'(bus.out_valid1), 64'(n >= 2));
    check("out_pc0", 64'(bus.out_pc0), 64'(p0));
    check("out_instr0", 64'(bus.out_instr0), 64'(i0));
    check("out_pc1", 64'(bus.out_pc1), 64'(p1));
    check("out_instr1", 64'(bus.out_instr1), 64'(i1));
  endtask

  // One clock: check current outputs, drive inputs, advance, update the model.
  task automatic cycle(input logic [1:0] ic, input logic [ADDR_W-1:0] p0,
                       input logic [ADDR_W-1:0] p1, input logic [1:0] dc, input logic fl);
    int n, e, dr, d;
    check_outputs();
    bus.in_count  = ic;
    bus.in_pc0    = p0;
    bus.in_instr0 = mk_instr(p0);
    bus.in_pc1    = p1;
    bus.in_instr1 = mk_instr(p1);
    bus.deq_count = dc;
    bus.flush     = fl;
    n  = sb.size();
    e  = (((DEPTH - n) >= 2) && (ic == 2'd1 || ic == 2'd2)) ? int'(ic) : 0;
    dr = (dc == 2'd3) ? 2 : int'(dc);
    d  = (dr < n) ? dr : n;
    @(posedge clock);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      repeat (d) void'(sb.pop_front());
      if (e >= 1) sb.push_back('{pc: p0, instr: mk_instr(p0)});
      if (e == 2) sb.push_back('{pc: p1, instr: mk_instr(p1)});
    end
    bus.in_count  = 2'd0;
    bus.deq_count = 2'd0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] p;
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_count  = 2'd0;
    bus.in_pc0    = '0;
    bus.in_instr0 = '0;
    bus.in_pc1    = '0;
    bus.in_instr1 = '0;
    bus.deq_count = 2'd0;

    // Reset then idle
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_instr0", 64'(bus.out_instr0), 64'd0);
    cycle(2'd0, '0, '0, 2'd0, 1'b0);

    // Single push/pop
    bus.in_count  = 2'd2;
    bus.in_pc0    = 12'h004;
    bus.in_instr0 = 32'h2840_0005;
    bus.in_pc1    = 12'h005;
    bus.in_instr1 = 32'h2880_0007;
    @(posedge clock);
    #1;
    bus.in_count = 2'd0;
    check("pair_valid1", 64'(bus.out_valid1), 64'd1);
    check("pair_pc0", 64'(bus.out_pc0), 64'h004);
    check("pair_instr0", 64'(bus.out_instr0), 64'h2840_0005);
    check("pair_pc1", 64'(bus.out_pc1), 64'h005);
    check("pair_instr1", 64'(bus.out_instr1), 64'h2880_0007);
    bus.deq_count = 2'd1;
    @(posedge clock);
    #1;
    bus.deq_count = 2'd0;
    check("pop1_pc0", 64'(bus.out_pc0), 64'h005);
    check("pop1_valid1", 64'(bus.out_valid1), 64'd0);
    check("pop1_count", 64'(bus.count), 64'd1);
    sb.push_back('{pc: 12'h005, instr: 32'h2880_0007});
    cycle(2'd0, '0, '0, 2'd1, 1'b0);

    // Fill to full, drop a fifth offer, drain singly
    for (int i = 0; i < 4; i++) cycle(2'd2, 12'(16 + 2 * i), 12'(17 + 2 * i), 2'd0, 1'b0);
    check("full_count", 64'(bus.count), 64'd8);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(2'd1, 12'h100, 12'h101, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(2'd0, '0, '0, 2'd1, 1'b0);
    check("drained_count", 64'(bus.count), 64'd0);

    // Wrap-around with steady 2-in/2-out
    p = 12'h200;
    cycle(2'd2, p, p + 12'd1, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      p = p + 12'd2;
      cycle(2'd2, p, p + 12'd1, 2'd2, 1'b0);
    end
    cycle(2'd0, '0, '0, 2'd2, 1'b0);

    // DEPTH-2 with simultaneous push and pop stays put
    for (int i = 0; i < 3; i++) cycle(2'd2, 12'(12'h300 + 2 * i), 12'(12'h301 + 2 * i), 2'd0, 1'b0);
    cycle(2'd2, 12'h310, 12'h311, 2'd2, 1'b0);
    check("dm2_count", 64'(bus.count), 64'(DEPTH - 2));
    for (int i = 0; i < 3; i++) cycle(2'd0, '0, '0, 2'd2, 1'b0);

    // Flush mid-stream discards same-cycle push and pop
    cycle(2'd2, 12'h020, 12'h021, 2'd0, 1'b0);
    cycle(2'd2, 12'h022, 12'h023, 2'd0, 1'b0);
    cycle(2'd1, 12'h024, 12'h025, 2'd0, 1'b0);
    check("preflush_count", 64'(bus.count), 64'd5);
    cycle(2'd2, 12'h026, 12'h027, 2'd2, 1'b1);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_valid0", 64'(bus.out_valid0), 64'd0);
    cycle(2'd1, 12'h040, 12'h041, 2'd0, 1'b0);
    check("postflush_pc0", 64'(bus.out_pc0), 64'h040);

    // Boundary clamps
    cycle(2'd0, '0, '0, 2'd2, 1'b0);
    check("underflow_count", 64'(bus.count), 64'd0);
    cycle(2'd3, 12'h050, 12'h051, 2'd0, 1'b0);
    check("in3_count", 64'(bus.count), 64'd0);
    for (int i = 0; i < 3; i++) cycle(2'd2, 12'(12'h060 + 2 * i), 12'(12'h061 + 2 * i), 2'd0, 1'b0);
    cycle(2'd1, 12'h066, 12'h067, 2'd0, 1'b0);
    check("cnt7_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(2'd2, 12'h070, 12'h071, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(2'd0, '0, '0, 2'd3, 1'b0);

    // Reset mid-stream overrides a same-cycle push
    cycle(2'd2, 12'h080, 12'h081, 2'd0, 1'b0);
    reset        = 1'b1;
    bus.in_count = 2'd2;
    bus.in_pc0   = 12'h082;
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.in_count = 2'd0;
    sb.delete();
    check("midrst_count", 64'(bus.count), 64'd0);
    cycle(2'd0, '0, '0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
